// File: rtl/pe_psum_accumulator.sv
// pe_psum_accumulator: sums each group of COUNT input values into an
// ACC_WIDTH-bit partial sum and presents it on a one-entry output register
// with a valid/ready handshake. The next group keeps accumulating while a
// completed sum waits, so only the final beat of a group can be stalled.
module pe_psum_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int COUNT     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int CNT_W = $clog2(COUNT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf_acc;
    logic [CNT_W-1:0]     cnt;

    logic [ACC_WIDTH:0]   sum_ext;
    logic                 in_beat;
    logic                 out_beat;
    logic                 final_beat;

    // Zero-extended add with the carry out of the top accumulator bit kept.
    always_comb begin
        sum_ext = {1'b0, acc} + (ACC_WIDTH + 1)'(in_data);
    end

    // Handshake decode; the final beat waits only while an unconsumed sum
    // occupies the output register.
    always_comb begin
        // NOTE: out_ready feeds in_ready combinationally on purpose, so a
        // consumer taking the old sum lets the final beat in the same cycle.
        in_ready   = !rst && !clear && !(cnt == LAST && out_valid && !out_ready);
        in_beat    = in_valid && in_ready;
        out_beat   = out_valid && out_ready;
        final_beat = in_beat && (cnt == LAST);
    end

    // Accumulator, group counter and output register updates.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            acc       <= '0;
            ovf_acc   <= 1'b0;
            cnt       <= '0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // A consumed output empties the register; a simultaneous final
            // beat below overrides this and reloads it.
            if (out_beat) begin
                out_valid <= 1'b0;
            end

            if (clear) begin
                // Drops only the partial group; a pending output survives.
                acc     <= '0;
                ovf_acc <= 1'b0;
                cnt     <= '0;
            end else if (final_beat) begin
                out_data  <= sum_ext[ACC_WIDTH-1:0];
                out_ovf   <= ovf_acc | sum_ext[ACC_WIDTH];
                out_valid <= 1'b1;
                acc       <= '0;
                ovf_acc   <= 1'b0;
                cnt       <= '0;
            end else if (in_beat) begin
                acc     <= sum_ext[ACC_WIDTH-1:0];
                ovf_acc <= ovf_acc | sum_ext[ACC_WIDTH];
                cnt     <= cnt + 1'b1;
            end
        end
    end

endmodule
